// File: rtl/tdc7200_spi_responder.sv
// TDC7200 register-interface stand-in: SPI mode-0 slave with config registers,
// a timed pseudo-measurement started by a CONFIG1 START write, and result
// registers latched from input ports when the measurement completes.
//
// SPI FSM
//   state   | meaning
//   S_IDLE  | cs_n high, waiting for cs_n to fall
//   S_CMD   | shifting in the 8-bit command byte
//   S_WDATA | shifting in write data, one byte per commit
//   S_RDATA | shifting out read data (8 or 24 bits per register)
//   S_DONE  | transfer finished, miso held 0 until cs_n rises
//
// Measurement FSM
//   state   | meaning
//   M_IDLE  | no measurement running
//   M_BUSY  | down-counting towards result latch
//   M_DONE  | results latched this cycle, returns to M_IDLE
module tdc7200_spi_responder #(
  parameter int MEAS_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        sck_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic        irq_o,
  input  logic [23:0] meas_time1_i,
  input  logic [23:0] meas_clock_count1_i,
  input  logic [23:0] meas_time2_i,
  input  logic [23:0] meas_cal1_i,
  input  logic [23:0] meas_cal2_i
);

  localparam int CW = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEAS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_DONE
  } spi_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_BUSY,
    M_DONE
  } meas_state_t;

  // Disabled chip behaves exactly like a chip in reset.
  logic clr;
  assign clr = ~rst | ~en_i;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall;

  // Bring the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk) begin
    if (clr) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // ---------------------------------------------------------------------------
  // Register file storage
  // ---------------------------------------------------------------------------
  logic [7:0]  config1_q, config2_q, int_mask_q;
  logic        int_status_q;
  logic        irq_q;
  logic [23:0] time1_q, clock_count1_q, time2_q, cal1_q, cal2_q;

  // ---------------------------------------------------------------------------
  // SPI FSM
  // ---------------------------------------------------------------------------
  spi_state_t  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        ainc_q, ainc_d;
  logic [5:0]  addr_q, addr_d;
  logic [6:0]  rx_q, rx_d;
  logic [23:0] tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q;

  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_1c_done;
  logic [5:0]  ld_addr;
  logic [23:0] ld_value;
  logic [4:0]  last_bit;

  // Registers holding the SPI transfer state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      ainc_q    <= 1'b0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ainc_q    <= ainc_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      miso_oe_q <= ~cs_s;
    end
  end

  // The shift register is loaded either from the just-decoded command address
  // or, on auto-increment, from the following address.
  assign ld_addr  = (state_q == S_CMD) ? {rx_q[4:0], mosi_s} : addr_q + 6'd1;
  assign last_bit = (addr_q[5:4] == 2'b01) ? 5'd23 : 5'd7;

  // Read mux; 8-bit registers are left-aligned so the MSB always leaves first.
  always_comb begin
    ld_value = '0;
    case (ld_addr)
      6'h00:   ld_value = {config1_q, 16'h0000};
      6'h01:   ld_value = {config2_q, 16'h0000};
      6'h02:   ld_value = {7'b0, int_status_q, 16'h0000};
      6'h03:   ld_value = {int_mask_q, 16'h0000};
      6'h10:   ld_value = time1_q;
      6'h11:   ld_value = clock_count1_q;
      6'h12:   ld_value = time2_q;
      6'h1B:   ld_value = cal1_q;
      6'h1C:   ld_value = cal2_q;
      default: ld_value = '0;
    endcase
  end

  // SPI next-state logic: command decode, write commit, read shifting.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ainc_d     = ainc_q;
    addr_d     = addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    wr_en      = 1'b0;
    wr_addr    = addr_q;
    wr_data    = {rx_q, mosi_s};
    rd_1c_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
        end
      end

      S_CMD: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          rx_d      = {rx_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            ainc_d    = rx_q[6];
            addr_d    = {rx_q[4:0], mosi_s};
            if (rx_q[5]) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RDATA;
              tx_d    = ld_value;
            end
          end
        end
      end

      S_WDATA: begin
        miso_d = 1'b0;
        if (sck_rise) begin
          rx_d      = {rx_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            wr_en     = 1'b1;
            bit_cnt_d = '0;
            if (ainc_q) begin
              addr_d = addr_q + 6'd1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_RDATA: begin
        if (sck_fall) begin
          miso_d = tx_q[23];
          tx_d   = {tx_q[22:0], 1'b0};
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d  = '0;
            rd_1c_done = (addr_q == 6'h1C);
            if (ainc_q) begin
              addr_d = addr_q + 6'd1;
              tx_d   = ld_value;
            end else begin
              state_d = S_DONE;
              miso_d  = 1'b0;
            end
          end
        end
      end

      S_DONE: begin
        miso_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // Deselect aborts anything in flight; partial bytes are simply dropped.
    if (cs_s) begin
      state_d    = S_IDLE;
      miso_d     = 1'b0;
      wr_en      = 1'b0;
      rd_1c_done = 1'b0;
    end
  end

  assign miso_o    = miso_q;
  assign miso_oe_o = miso_oe_q;
  assign irq_o     = irq_q;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  meas_state_t   m_state_q, m_state_d;
  logic [CW-1:0] cnt_q;
  logic          start_w;
  logic          meas_fire;

  assign start_w   = wr_en && (wr_addr == 6'h00) && wr_data[0];
  assign meas_fire = (m_state_q == M_BUSY) && (cnt_q == '0) && !start_w;

  // Measurement state register.
  always_ff @(posedge clk) begin
    if (clr) m_state_q <= M_IDLE;
    else     m_state_q <= m_state_d;
  end

  // Measurement next-state; a new START always (re)enters M_BUSY.
  always_comb begin
    m_state_d = m_state_q;
    case (m_state_q)
      M_IDLE:  if (start_w) m_state_d = M_BUSY;
      M_BUSY:  if (start_w) m_state_d = M_BUSY;
               else if (cnt_q == '0) m_state_d = M_DONE;
      M_DONE:  m_state_d = start_w ? M_BUSY : M_IDLE;
      default: m_state_d = M_IDLE;
    endcase
  end

  // Measurement down-counter; reaching zero in M_BUSY triggers the latch.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (start_w) begin
      cnt_q <= CNT_LOAD;
    end else if ((m_state_q == M_BUSY) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Register file updates: SPI writes first, then clears, then completion so
  // a completion event is never lost to a same-cycle config write.
  always_ff @(posedge clk) begin
    if (clr) begin
      config1_q      <= 8'h00;
      config2_q      <= 8'h40;
      int_status_q   <= 1'b0;
      int_mask_q     <= 8'h07;
      irq_q          <= 1'b0;
      time1_q        <= '0;
      clock_count1_q <= '0;
      time2_q        <= '0;
      cal1_q         <= '0;
      cal2_q         <= '0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          6'h00: config1_q <= wr_data;
          6'h01: config2_q <= wr_data;
          6'h02: if (wr_data[0]) begin
                   int_status_q <= 1'b0;
                   irq_q        <= 1'b0;
                 end
          6'h03: int_mask_q <= wr_data;
          default: ;
        endcase
      end
      if (start_w || rd_1c_done) irq_q <= 1'b0;
      if (meas_fire) begin
        time1_q        <= meas_time1_i;
        clock_count1_q <= meas_clock_count1_i;
        time2_q        <= meas_time2_i;
        cal1_q         <= meas_cal1_i;
        cal2_q         <= meas_cal2_i;
        int_status_q   <= 1'b1;
        config1_q[0]   <= 1'b0;
        if (int_mask_q[0]) irq_q <= 1'b1;
      end
    end
  end

endmodule
